prog_loader: RTL

// - Byte-stream program loader: writer side of the processor's instruction memory.
// - Accepts a framed byte stream, assembles 32-bit big-endian words and writes them into the program memory write port.
// - Then asserts cpu_run and presents start_pc to the core's initial_pc input.
// - Sits between the host/UART byte source and the program memory; the core holds off until cpu_run.

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/prog_loader_if.sv | 21 ++
 rtl/prog_loader_byte_assembler.sv | 34 +++
 rtl/prog_loader.sv | 128 ++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_BASE,
        HDR_LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    // States in which the loader is consuming stream bytes.
    function automatic logic is_active(input state_t s);
        return (s == HDR_BASE) || (s == HDR_LEN) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input handshake plus program memory write port of the loader.
interface prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              pm_we;
    logic [ADDR_W-1:0] pm_addr;
    logic [31:0]       pm_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, pm_we, pm_addr, pm_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, pm_we, pm_addr, pm_wdata
    );
endinterface

// File: rtl/prog_loader_byte_assembler.sv
// Collects four stream bytes, MSB first, into a 32-bit word.
module byte_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    logic [23:0] shift;
    logic [1:0]  count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift <= '0;
            count <= '0;
        end else if (clear) begin
            shift <= '0;
            count <= '0;
        end else if (accept) begin
            shift <= {shift[15:0], byte_in};
            count <= count + 2'd1;
        end
    end

    // The word is complete in the same cycle its fourth byte is on the bus.
    assign word      = {shift, byte_in};
    assign word_done = accept && (count == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// Frame parser and program memory writer; releases the core with cpu_run.
// Optional trailer checksum enabled by defining PROG_LOADER_CSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_start,
    prog_loader_if.slave bus,
    output logic [31:0]  start_pc,
    output logic         cpu_run,
    output logic         busy,
    output logic         err
);

    localparam logic [32:0] DEPTH     = 33'd1 << ADDR_W;
    localparam logic [32:0] LEN_LIMIT = 33'd1 << LEN_W;

`ifdef PROG_LOADER_CSUM_EN
    localparam state_t POST_DATA = CSUM;
`else
    localparam state_t POST_DATA = DONE;
`endif

    state_t            state, state_next;
    logic              accept;
    logic [31:0]       word;
    logic              word_done;
    logic [ADDR_W-1:0] addr_cnt;
    logic [LEN_W-1:0]  words_left;
    logic [32:0]       hdr_end;
    logic              hdr_bad;
`ifdef PROG_LOADER_CSUM_EN
    logic [31:0]       csum;
`endif

    assign accept = bus.in_valid && bus.in_ready;

    byte_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_next != state),
        .accept    (accept),
        .byte_in   (bus.in_data),
        .word      (word),
        .word_done (word_done)
    );

    // Header is judged against the base latched in start_pc and the incoming count word.
    assign hdr_end = {1'b0, start_pc} + {1'b0, word};
    assign hdr_bad = ({1'b0, start_pc} >= DEPTH) || ({1'b0, word} >= LEN_LIMIT) || (hdr_end > DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        bus.in_ready = is_active(state);
        busy         = is_active(state);
        err          = (state == ERR);
        case (state)
            IDLE, DONE, ERR: if (load_start) state_next = HDR_BASE;
            HDR_BASE:        if (word_done) state_next = HDR_LEN;
            HDR_LEN: begin
                if (word_done) begin
                    if (hdr_bad)           state_next = ERR;
                    else if (word == '0)   state_next = POST_DATA;
                    else                   state_next = DATA;
                end
            end
            DATA:            if (word_done && words_left == LEN_W'(1)) state_next = POST_DATA;
`ifdef PROG_LOADER_CSUM_EN
            CSUM:            if (word_done) state_next = (word == csum) ? DONE : ERR;
`endif
            default:         state_next = IDLE;
        endcase
    end

    // cpu_run waits one cycle in DONE so it trails the final write pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.pm_we    <= 1'b0;
            bus.pm_addr  <= '0;
            bus.pm_wdata <= '0;
            start_pc     <= '0;
            cpu_run      <= 1'b0;
            addr_cnt     <= '0;
            words_left   <= '0;
`ifdef PROG_LOADER_CSUM_EN
            csum         <= '0;
`endif
        end else begin
            bus.pm_we <= 1'b0;
            cpu_run   <= (state == DONE) && (state_next == DONE);
            case (state)
`ifdef PROG_LOADER_CSUM_EN
                IDLE, DONE, ERR: if (load_start) csum <= '0;
`endif
                HDR_BASE: if (word_done) start_pc <= word;
                HDR_LEN: begin
                    if (word_done) begin
                        addr_cnt   <= start_pc[ADDR_W-1:0];
                        words_left <= word[LEN_W-1:0];
                    end
                end
                DATA: begin
                    if (word_done) begin
                        bus.pm_we    <= 1'b1;
                        bus.pm_addr  <= addr_cnt;
                        bus.pm_wdata <= word;
                        addr_cnt     <= addr_cnt + 1'b1;
                        words_left   <= words_left - 1'b1;
`ifdef PROG_LOADER_CSUM_EN
                        csum         <= csum + word;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
